// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: instruction-memory request/ack, redirect from execute,
// and the decode-facing instruction queue head. The sequencer uses the
// master side, memory/decode/execute models use the slave side.
interface fetch_sequencer_if;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fault;

   modport master (
      input  stall, redirect_valid, redirect_addr, imem_ack, imem_rdata,
      output imem_req, imem_addr, instr_valid, instr, instr_pc, fault
   );

   modport slave (
      output stall, redirect_valid, redirect_addr, imem_ack, imem_rdata,
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, fault
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues word fetches, queues 2 instructions to decode.
// Latency: instr_valid 1 cycle after the acking edge; 1 instr/cycle with same-cycle ack.
// Backpressure: stall holds the queue; no new request unless a slot is free next edge.
// Optional FETCH_SEQ_TIMEOUT_EN: request-wait timeout raising a sticky fault and halting.
module fetch_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
`ifdef FETCH_SEQ_TIMEOUT_EN
   , parameter int unsigned TIMEOUT = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   fetch_sequencer_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] hold_addr;     // address of the request being drained in DISCARD
   logic [1:0]  cnt;
   logic [1:0]  cnt_after;     // occupancy at next edge, ignoring flush
   logic [31:0] q0_ins, q0_pc, q1_ins, q1_pc;
   logic        push, pop, flush, timeout_hit;

   // Queue traffic this cycle; a redirect overrides the push of acked data.
   always_comb begin
      pop       = (cnt != 2'd0) && !bus.stall;
      push      = (state == REQ) && bus.imem_ack && !bus.redirect_valid;
      cnt_after = cnt + {1'b0, push} - {1'b0, pop};
   end

   // Next state and next PC; redirect has priority over everything but HALT.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         IDLE: begin
            if (bus.redirect_valid) begin
               state_nxt = REQ;
               pc_nxt    = bus.redirect_addr;
            end else if (cnt_after <= 2'd1) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (bus.redirect_valid) begin
               pc_nxt    = bus.redirect_addr;
               state_nxt = bus.imem_ack ? REQ : DISCARD;
            end else if (bus.imem_ack) begin
               pc_nxt    = pc + 32'd1;
               state_nxt = (cnt_after <= 2'd1) ? REQ : IDLE;
            end
         end
         DISCARD: begin
            if (bus.redirect_valid) pc_nxt = bus.redirect_addr;
            if (bus.imem_ack)       state_nxt = REQ;
         end
         default: ;
      endcase
      if (timeout_hit) state_nxt = HALT;
      flush = (bus.redirect_valid && (state != HALT)) || (state_nxt == HALT);
   end

   // State, PC and the held address of a request that must be drained.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         pc        <= RESET_VEC;
         hold_addr <= RESET_VEC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if ((state == REQ) && bus.redirect_valid && !bus.imem_ack) hold_addr <= pc;
      end
   end

   // Two-entry instruction queue, head in q0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt    <= 2'd0;
         q0_ins <= 32'd0;
         q0_pc  <= 32'd0;
         q1_ins <= 32'd0;
         q1_pc  <= 32'd0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else begin
         cnt <= cnt_after;
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) begin
                  q0_ins <= bus.imem_rdata;
                  q0_pc  <= pc;
               end else begin
                  q1_ins <= bus.imem_rdata;
                  q1_pc  <= pc;
               end
            end
            2'b01: begin
               q0_ins <= q1_ins;
               q0_pc  <= q1_pc;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  q0_ins <= bus.imem_rdata;
                  q0_pc  <= pc;
               end else begin
                  q0_ins <= q1_ins;
                  q0_pc  <= q1_pc;
                  q1_ins <= bus.imem_rdata;
                  q1_pc  <= pc;
               end
            end
            default: ;
         endcase
      end
   end

   // Memory request and decode-facing outputs.
   always_comb begin
      bus.imem_req    = (state == REQ) || (state == DISCARD);
      bus.imem_addr   = (state == DISCARD) ? hold_addr : pc;
      bus.instr_valid = (cnt != 2'd0);
      bus.instr       = q0_ins;
      bus.instr_pc    = q0_pc;
   end

`ifdef FETCH_SEQ_TIMEOUT_EN
   logic [31:0] wait_cnt;
   logic        fault_q;

   // Timeout fires on the edge that ends the TIMEOUT-th unacked request cycle.
   always_comb begin
      timeout_hit = bus.imem_req && !bus.imem_ack && (wait_cnt == TIMEOUT - 1);
   end

   // Wait counter clears whenever no request is pending or it completes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt <= 32'd0;
         fault_q  <= 1'b0;
      end else begin
         if (timeout_hit) fault_q <= 1'b1;
         if (!bus.imem_req || bus.imem_ack) wait_cnt <= 32'd0;
         else                               wait_cnt <= wait_cnt + 32'd1;
      end
   end

   assign bus.fault = fault_q;
`else
   // Without the timeout requests wait indefinitely and HALT is unreachable.
   always_comb begin
      timeout_hit = 1'b0;
   end

   assign bus.fault = 1'b0;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that owns the program counter sequence and drives the instruction-memory request handshake. It issues word-addressed fetches (PC increments by 1), buffers returned instructions in a 2-entry queue toward decode, and applies branch/jump redirects from execute, including discarding responses for in-flight requests. Sits between the PC/next-address logic and the decode stage.

## Interface
- RESET_VEC, 32'h00000000, first fetch address after reset
- TIMEOUT, 16, max cycles a request may wait for ack (only with FETCH_SEQ_TIMEOUT_EN)

- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- stall  in  1  decode not accepting; head entry consumed when instr_valid & !stall
- redirect_valid  in  1  single-cycle redirect request from execute
- redirect_addr  in  32  redirect target (word address)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, stable while imem_req high
- imem_ack  in  1  request complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  queue head valid
- instr  out  32  queue head instruction
- instr_pc  out  32  address of queue head
- fault  out  1  fetch timeout, sticky until reset

## Operation
- States: IDLE, REQ, DISCARD, HALT.
- IDLE: entered on reset. Moves to REQ on the first edge with rst=1 and a queue slot free.
- REQ: imem_req=1, imem_addr=pc. The request is never withdrawn; it is held with a stable address until imem_ack=1. An ack in the same cycle the request is raised completes it.
  - On ack: push {imem_rdata, pc}; pc<=pc+1.
  - Stay in REQ if, after this cycle's push and pop, the queue has a free slot. Otherwise go to IDLE.
- Queue: 2 entries, FIFO, head on instr/instr_pc.
  - Push and pop in the same cycle is allowed.
  - A new request is raised only when, counting the pop this cycle, at most 1 entry will be occupied at the next edge. The queue therefore never overflows.
- Redirect (highest priority, overrides stall and push):
  - Queue flushed; instr_valid=0 next cycle.
  - pc<=redirect_addr.
  - If a request is outstanding with no ack this cycle: go to DISCARD. imem_req stays high at the old address until ack; that data is dropped; next cycle issue redirect_addr.
  - If ack coincides with redirect: data dropped; next cycle imem_req=1 at redirect_addr.
  - If no request is outstanding: next cycle imem_req=1 at redirect_addr.
  - Redirect during DISCARD: pc overwritten (latest wins); a single discard remains.
- pc arithmetic is 32-bit modulo; 32'hFFFFFFFF+1 wraps to 0.
- HALT: only with the timeout feature. imem_req=0, queue flushed, redirect ignored; leave only by reset.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_VEC, instr_valid=0, instr=0, instr_pc=0, fault=0, queue empty, pc=RESET_VEC.
- First imem_req high: the cycle after the first edge sampling rst=1.
- Fetch latency: instr_valid rises 1 cycle after the acking edge.
- Throughput: 1 instruction/cycle with same-cycle ack and stall=0.
- Redirect to first valid instruction: 2 cycles with same-cycle ack; plus the remaining wait of any discarded request.
- Reset mid-request: the request is abandoned immediately; a late ack after reset is ignored (IDLE does not accept ack).

## Configuration
- FETCH_SEQ_TIMEOUT_EN defined:
  - A counter counts cycles with imem_req=1 and imem_ack=0 (REQ and DISCARD); it clears on ack or redirect-issued request.
  - At count reaching TIMEOUT: fault<=1 and go to HALT.
- Undefined: no counter; fault tied 0; requests wait indefinitely; HALT unreachable.

## Test plan
- Reset release, ack always 1, stall 0 -> imem_addr 0,1,2,3 on consecutive cycles; instr_pc 0,1,2 one cycle later; instr matches rdata.
- stall held 5 cycles with ack=1 -> queue fills to 2; imem_req drops; no instruction lost or duplicated; fetch resumes at next pc after stall release.
- Redirect to 32'h100 while request at addr 5 awaits ack (ack after 3 cycles) -> addr-5 data dropped; next request addr 32'h100; instr_valid stays 0 until 32'h100 returns.
- Redirect coincident with ack and stall=1 -> queue flushed, ack data dropped, next imem_addr=redirect_addr.
- pc=32'hFFFFFFFF fetched -> next imem_addr 32'h00000000.
- FETCH_SEQ_TIMEOUT_EN, TIMEOUT=16, ack never asserted -> fault=1 after 16 waiting cycles; imem_req=0 thereafter; rst low clears fault and restarts at RESET_VEC.
